carry_lookahead_adder32: RTL and testbench
==========================================

Name: carry_lookahead_adder32

Overview:
- Parameterised two-level carry-lookahead adder. Default width is 32 bits.
- The combinational sum feeds the program-counter PC+4 path in the same cycle, so no clock is needed on that path.
- A registered copy of the sum and carry-out is also provided, for datapaths that need one cycle of latency.
- Built from 4-bit lookahead groups plus a second-level group-carry unit. There is no ripple chain across groups.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of GROUP.
- GROUP, 4, bits per lookahead group. Fixed at 4; elaboration error if changed.

Ports:
- i_clk  input  1  clock. Rising edge.
- i_rst  input  1  reset. Synchronous, active-high.
- i_en  input  1  register-stage load enable.
- i_add1  input  WIDTH  operand A.
- i_add2  input  WIDTH  operand B.
- i_carry_in  input  1  carry into bit 0. Tie to 0 for plain addition.
- o_result  output  WIDTH  combinational sum, (A+B+cin) mod 2^WIDTH.
- o_carry_out  output  1  combinational carry out of the MSB.
- o_r_result  output  WIDTH  registered sum.
- o_r_carry_out  output  1  registered carry out.

Behaviour:
- Per-bit terms: g[i]=A[i]&B[i], p[i]=A[i]^B[i], sum[i]=p[i]^c[i].
- Within each group, carries use lookahead:
  - c1 = g0 | p0·c0
  - c2 = g1 | p1·g0 | p1·p0·c0
  - c3 and c4 follow the same expansion.
- Each group exports group generate GG and group propagate GP = p3·p2·p1·p0.
- The second level computes each group's carry-in from GG/GP and i_carry_in, using lookahead over the group terms.
- o_carry_out is the carry out of the top group.
- o_result and o_carry_out are purely combinational: zero latency, valid in the same cycle as the inputs.
- Results are unsigned modulo 2^WIDTH. Wrap-around is silent except through o_carry_out, e.g. 0xFFFFFFFC+4 gives 0x00000000 with carry 1.
- Registered stage, on rising i_clk:
  - i_rst=1 sets o_r_result=0 and o_r_carry_out=0. Reset wins over i_en.
  - else if i_en=1, load o_result and o_carry_out.
  - else hold.
- Register latency is 1 cycle.
- Power-up: register values are undefined until the first reset edge. The combinational outputs are unaffected by reset.
- Reset asserted mid-operation clears only the registers, on that edge. The combinational path keeps tracking the inputs.
- X or Z on any operand bit may propagate; the design has no X-masking.

Optional Feature:
- Macro: CLA_FLAGS_EN.
- Defined: adds combinational outputs, each 1 bit:
  - o_overflow = (A[MSB]==B[MSB]) & (sum[MSB]!=A[MSB]), signed overflow.
  - o_zero = (o_result==0).
- Also adds registered copies o_r_overflow and o_r_zero, with the same reset/enable rules as o_r_result.
- Undefined: these four ports do not exist. The rest of the behaviour is identical.

Decomposition:
- Package cla_pkg holds:
  - constants CLA_WIDTH=32 and CLA_GROUP=4;
  - derived CLA_NGROUPS=CLA_WIDTH/CLA_GROUP;
  - a typedef for the per-group {GG, GP} pair.
- Sub-module cla_group4: 4-bit lookahead block.
  - Inputs a[3:0], b[3:0], cin.
  - Outputs sum[3:0], gg, gp.
  - WIDTH/GROUP instances are generated.
- The top level holds the second-level carry unit and the output registers.

Test Plan:
- Combinational PC+4: A=0x00000000, B=4, cin=0 → o_result=0x00000004, carry 0, same cycle. Then A=0x00001000 → 0x00001004.
- Full carry propagation: A=0xFFFFFFFC, B=4 → result 0x00000000, carry 1. Then A=0xFFFFFFFF, B=0, cin=1 → 0x00000000, carry 1.
- Group-boundary carries: A=0x0000000F, B=1 → 0x00000010. A=0x0FFFFFFF, B=1 → 0x10000000. With CLA_FLAGS_EN: A=0x7FFFFFFC, B=4 → 0x80000000, o_overflow=1.
- Register stage:
  - with i_en=1, result appears on o_r_result one edge later;
  - with i_en=0, inputs change but o_r_result holds;
  - i_rst=1 together with i_en=1 → o_r_result=0, o_r_carry_out=0 after the edge.
- Randomised: 10k random A, B, cin compared against the behavioural (A+B+cin), checking all WIDTH+1 bits for both combinational and registered outputs.

Source files
------------

// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared constants and types for the two-level carry-lookahead adder.
//   CLA_WIDTH   : default operand/result width
//   CLA_GROUP   : bits per lookahead group (fixed at 4)
//   CLA_NGROUPS : number of first-level groups
//   cla_gterm_t : per-group {generate, propagate} pair exported to level two
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int CLA_WIDTH   = 32;
    localparam int CLA_GROUP   = 4;
    localparam int CLA_NGROUPS = CLA_WIDTH / CLA_GROUP;

    typedef struct packed {
        logic gg;   // group generate
        logic gp;   // group propagate
    } cla_gterm_t;

endpackage : cla_pkg

// File: rtl/cla_group4.sv
// -----------------------------------------------------------------------------
// cla_group4
// 4-bit carry-lookahead block. Internal carries are fully expanded from the
// group carry-in, so no ripple exists inside the group. The group generate and
// propagate terms do not depend on cin, which lets the second level compute
// every group carry-in in parallel.
// Ports:
//   a, b : 4-bit operand slices
//   cin  : carry into bit 0 of this group
//   sum  : 4-bit sum slice
//   gg   : group generate  (carry out of the group regardless of cin)
//   gp   : group propagate (cin passes straight to the group carry out)
// -----------------------------------------------------------------------------
module cla_group4
    import cla_pkg::*;
(
    input  logic [CLA_GROUP-1:0] a,
    input  logic [CLA_GROUP-1:0] b,
    input  logic                 cin,
    output logic [CLA_GROUP-1:0] sum,
    output logic                 gg,
    output logic                 gp
);

    logic [CLA_GROUP-1:0] g;
    logic [CLA_GROUP-1:0] p;
    logic [CLA_GROUP-1:0] c;

    always_comb begin
        g = a & b;
        p = a ^ b;

        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);

        sum = p ^ c;

        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
        gp = &p;
    end

endmodule : cla_group4

// File: rtl/carry_lookahead_adder32.sv
// -----------------------------------------------------------------------------
// carry_lookahead_adder32
// Two-level carry-lookahead adder with a combinational result (used directly
// by the PC+4 path) and a one-cycle registered copy.
// Optional feature macro: CLA_FLAGS_EN adds signed-overflow and zero flags,
// both combinational and registered.
// Ports:
//   i_clk, i_rst     : clock (rising edge), synchronous active-high reset
//   i_en             : load enable for the registered outputs
//   i_add1, i_add2   : operands A and B
//   i_carry_in       : carry into bit 0
//   o_result         : combinational (A+B+cin) mod 2^WIDTH
//   o_carry_out      : combinational carry out of the MSB
//   o_r_result       : registered sum
//   o_r_carry_out    : registered carry out
//   o_overflow, o_zero, o_r_overflow, o_r_zero : only with CLA_FLAGS_EN
// -----------------------------------------------------------------------------
module carry_lookahead_adder32
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    input  logic             i_carry_in,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry_out,
    output logic [WIDTH-1:0] o_r_result,
    output logic             o_r_carry_out
`ifdef CLA_FLAGS_EN
    ,
    output logic             o_overflow,
    output logic             o_zero,
    output logic             o_r_overflow,
    output logic             o_r_zero
`endif
);

    localparam int NG = WIDTH / GROUP;

    // The group block is hand-expanded for 4 bits only.
    if (GROUP != 4) begin : g_bad_group
        $error("carry_lookahead_adder32: GROUP must be 4");
    end
    if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_bad_width
        $error("carry_lookahead_adder32: WIDTH must be a positive multiple of GROUP");
    end

    cla_gterm_t [NG-1:0] gt;
    logic       [NG:0]   gcin;   // gcin[k] = carry into group k, gcin[NG] = carry out
    logic [WIDTH-1:0]    sum;

    // First level: one lookahead block per 4-bit slice.
    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group4 u_grp (
            .a   (i_add1[k*GROUP +: GROUP]),
            .b   (i_add2[k*GROUP +: GROUP]),
            .cin (gcin[k]),
            .sum (sum[k*GROUP +: GROUP]),
            .gg  (gt[k].gg),
            .gp  (gt[k].gp)
        );
    end

    // Second level: each group carry is a flat sum-of-products over the group
    // terms below it and i_carry_in, so no carry ripples from group to group.
    always_comb begin
        logic acc;
        logic term;
        gcin    = '0;
        gcin[0] = i_carry_in;
        for (int k = 0; k < NG; k++) begin
            acc = i_carry_in;
            for (int m = 0; m <= k; m++) begin
                acc = acc & gt[m].gp;
            end
            for (int j = 0; j <= k; j++) begin
                term = gt[j].gg;
                for (int m = j + 1; m <= k; m++) begin
                    term = term & gt[m].gp;
                end
                acc = acc | term;
            end
            gcin[k+1] = acc;
        end
    end

    assign o_result    = sum;
    assign o_carry_out = gcin[NG];

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d,  carry_q;

    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        if (i_en) begin
            result_d = sum;
            carry_d  = gcin[NG];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign o_r_result    = result_q;
    assign o_r_carry_out = carry_q;

`ifdef CLA_FLAGS_EN
    logic overflow_c, zero_c;
    logic overflow_d, overflow_q;
    logic zero_d,     zero_q;

    // Signed overflow: operands share a sign that the sum does not.
    assign overflow_c = (i_add1[WIDTH-1] == i_add2[WIDTH-1])
                      & (sum[WIDTH-1] != i_add1[WIDTH-1]);
    assign zero_c     = (sum == '0);

    always_comb begin
        overflow_d = overflow_q;
        zero_d     = zero_q;
        if (i_en) begin
            overflow_d = overflow_c;
            zero_d     = zero_c;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign o_overflow   = overflow_c;
    assign o_zero       = zero_c;
    assign o_r_overflow = overflow_q;
    assign o_r_zero     = zero_q;
`endif

endmodule : carry_lookahead_adder32

// File: tb/tb_carry_lookahead_adder32.sv
// -----------------------------------------------------------------------------
// tb_carry_lookahead_adder32
// Self-checking bench for carry_lookahead_adder32 (default 32-bit build).
// Directed corner cases followed by randomized operands, compared against a
// plain arithmetic reference ({1'b0,A}+{1'b0,B}+cin). Flag checks are active
// when CLA_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_carry_lookahead_adder32;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] result;
    logic        carry;
    logic [31:0] r_result;
    logic        r_carry;
`ifdef CLA_FLAGS_EN
    logic        ovf;
    logic        zero;
    logic        r_ovf;
    logic        r_zero;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    carry_lookahead_adder32 dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_add1        (a),
        .i_add2        (b),
        .i_carry_in    (cin),
        .o_result      (result),
        .o_carry_out   (carry),
        .o_r_result    (r_result),
        .o_r_carry_out (r_carry)
`ifdef CLA_FLAGS_EN
        ,
        .o_overflow    (ovf),
        .o_zero        (zero),
        .o_r_overflow  (r_ovf),
        .o_r_zero      (r_zero)
`endif
    );

    // Reference: exact unsigned sum in 33 bits, {carry, result}.
    function automatic logic [32:0] ref_sum(input logic [31:0] x, input logic [31:0] y,
                                            input logic c);
        return {1'b0, x} + {1'b0, y} + {32'd0, c};
    endfunction

    // Reference signed overflow: true sum falls outside the 32-bit signed range.
    function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y,
                                     input logic c);
        longint s;
        s = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply operands away from the clock edge and check the same-cycle outputs.
    task automatic apply(input logic [31:0] x, input logic [31:0] y, input logic c,
                         input string tag);
        a   = x;
        b   = y;
        cin = c;
        #1;
        check(tag, {31'd0, carry, result}, {31'd0, ref_sum(x, y, c)});
    endtask

    logic [32:0] exp_q;
    logic        exp_ovf_q;
    logic        exp_zero_q;

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        a   = '0;
        b   = '0;
        cin = 1'b0;

        @(posedge clk); #1;
        check("reset_r_result", {32'd0, r_result}, 64'd0);
        check("reset_r_carry",  {63'd0, r_carry},  64'd0);
`ifdef CLA_FLAGS_EN
        check("reset_r_flags",  {62'd0, r_ovf, r_zero}, 64'd0);
`endif
        rst = 1'b0;

        // Combinational PC+4 and carry-chain corners with literal expectations.
        apply(32'h0000_0000, 32'd4, 1'b0, "pc4_zero");
        check("pc4_zero_lit", {31'd0, carry, result}, {31'd0, 1'b0, 32'h0000_0004});
        apply(32'h0000_1000, 32'd4, 1'b0, "pc4_1000");
        check("pc4_1000_lit", {31'd0, carry, result}, {31'd0, 1'b0, 32'h0000_1004});
        apply(32'hFFFF_FFFC, 32'd4, 1'b0, "wrap_fffc");
        check("wrap_fffc_lit", {31'd0, carry, result}, {31'd0, 1'b1, 32'h0000_0000});
        apply(32'hFFFF_FFFF, 32'd0, 1'b1, "wrap_cin");
        check("wrap_cin_lit", {31'd0, carry, result}, {31'd0, 1'b1, 32'h0000_0000});
        apply(32'h0000_000F, 32'd1, 1'b0, "grp_0f");
        check("grp_0f_lit", {31'd0, carry, result}, {31'd0, 1'b0, 32'h0000_0010});
        apply(32'h0FFF_FFFF, 32'd1, 1'b0, "grp_0fff");
        check("grp_0fff_lit", {31'd0, carry, result}, {31'd0, 1'b0, 32'h1000_0000});
        apply(32'h7FFF_FFFC, 32'd4, 1'b0, "ovf_edge");
        check("ovf_edge_lit", {31'd0, carry, result}, {31'd0, 1'b0, 32'h8000_0000});
`ifdef CLA_FLAGS_EN
        check("ovf_edge_flag", {63'd0, ovf},  64'd1);
        check("ovf_edge_zero", {63'd0, zero}, 64'd0);
        apply(32'hFFFF_FFFC, 32'd4, 1'b0, "zero_flag_sum");
        check("zero_flag", {62'd0, ovf, zero}, {62'd0, 1'b0, 1'b1});
        apply(32'h8000_0000, 32'h8000_0000, 1'b0, "neg_ovf_sum");
        check("neg_ovf_flag", {62'd0, ovf, zero}, {62'd0, 1'b1, 1'b1});
`endif

        // Register stage: load, hold, then reset beats enable.
        en = 1'b1;
        apply(32'h0000_1234, 32'h0000_0010, 1'b0, "reg_load_comb");
        @(posedge clk); #1;
        check("reg_load", {31'd0, r_carry, r_result}, {31'd0, 1'b0, 32'h0000_1244});

        en = 1'b0;
        apply(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "reg_hold_comb");
        @(posedge clk); #1;
        check("reg_hold", {31'd0, r_carry, r_result}, {31'd0, 1'b0, 32'h0000_1244});

        en = 1'b1;
        @(posedge clk); #1;
        check("reg_load_carry", {31'd0, r_carry, r_result}, {31'd0, 1'b1, 32'h0000_0001});

        rst = 1'b1;
        apply(32'h1234_5678, 32'h0000_0001, 1'b0, "rst_en_comb");
        @(posedge clk); #1;
        check("rst_over_en", {31'd0, r_carry, r_result}, 64'd0);
        check("rst_comb_live", {31'd0, carry, result}, {31'd0, 1'b0, 32'h1234_5679});
        rst = 1'b0;

        // Randomized operands, every 8th vector forced to a full propagate chain.
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            logic        c;
            x = $urandom;
            y = (i % 8 == 3) ? ~x : $urandom;
            c = 1'($urandom_range(0, 1));
            en = 1'b1;
            apply(x, y, c, "rand_comb");
            exp_q      = ref_sum(x, y, c);
            exp_ovf_q  = ref_ovf(x, y, c);
            exp_zero_q = (exp_q[31:0] == 32'd0);
`ifdef CLA_FLAGS_EN
            check("rand_flags", {62'd0, ovf, zero}, {62'd0, exp_ovf_q, exp_zero_q});
`endif
            @(posedge clk); #1;
            check("rand_reg", {31'd0, r_carry, r_result}, {31'd0, exp_q});
`ifdef CLA_FLAGS_EN
            check("rand_reg_flags", {62'd0, r_ovf, r_zero}, {62'd0, exp_ovf_q, exp_zero_q});
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_carry_lookahead_adder32
